// File: rtl/writeback_unit_if.sv
// MEM/WB-to-writeback bundle: latch contents and cache-flush handshake in, register-file
// write port, bypass entry, halt/freeze status and retire count out.
interface writeback_unit_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic [1:0]       MemtoReg;
  logic             RegWEN;
  logic             halt;
  logic             equal;
  logic [4:0]       rd;
  logic [31:0]      ALUOut;
  logic [31:0]      load;
  logic [31:0]      npc;
  logic [31:0]      portB;
  logic             flush_done;

  logic             rf_WEN;
  logic [4:0]       rf_wsel;
  logic [31:0]      rf_wdat;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [31:0]      fwd_data;
  logic             flush_req;
  logic             wb_freeze;
  logic             halt_out;
  logic [CNT_W-1:0] retired;

  modport master (
    output en, MemtoReg, RegWEN, halt, equal, rd, ALUOut, load, npc, portB, flush_done,
    input  rf_WEN, rf_wsel, rf_wdat, fwd_valid, fwd_rd, fwd_data,
           flush_req, wb_freeze, halt_out, retired
  );

  modport slave (
    input  en, MemtoReg, RegWEN, halt, equal, rd, ALUOut, load, npc, portB, flush_done,
    output rf_WEN, rf_wsel, rf_wdat, fwd_valid, fwd_rd, fwd_data,
           flush_req, wb_freeze, halt_out, retired
  );
endinterface

// File: rtl/writeback_unit.sv
// MIPS writeback: rf write port same cycle, bypass/count one edge later; halt runs RUN->FLUSH->DONE.
// Upstream is frozen while waiting on flush_done and after halt; there is no other backpressure.
module writeback_unit #(
  parameter int CNT_W = 32
) (
  input logic             CLK,
  input logic             RST,
  writeback_unit_if.slave wb
);

  typedef enum logic [1:0] {
    MTR_ALU  = 2'd0,
    MTR_LOAD = 2'd1,
    MTR_NPC  = 2'd2,
    MTR_LUI  = 2'd3
  } memtoreg_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fwd_valid_q, fwd_valid_d;
  logic [4:0]       fwd_rd_q, fwd_rd_d;
  logic [31:0]      fwd_data_q, fwd_data_d;

  logic             wen;
  logic [31:0]      wdat;
  logic             flush_req, wb_freeze, halt_out;
  logic             unused_inputs;

  assign unused_inputs = ^{wb.equal, wb.portB[31:16]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      retired_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= 5'd0;
      fwd_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  // flush_done is only honoured once we are actually waiting on the cache
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (wb.en && wb.halt) state_d = ST_FLUSH;
      ST_FLUSH: if (wb.flush_done)    state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    unique case (memtoreg_t'(wb.MemtoReg))
      MTR_ALU:  wdat = wb.ALUOut;
      MTR_LOAD: wdat = wb.load;
      MTR_NPC:  wdat = wb.npc;
      MTR_LUI:  wdat = {wb.portB[15:0], 16'h0000};
      default:  wdat = wb.ALUOut;
    endcase

    wen = wb.en && wb.RegWEN && !wb.halt && (wb.rd != 5'd0) && (state_q == ST_RUN);

    retired_d   = retired_q;
    fwd_valid_d = fwd_valid_q;
    fwd_rd_d    = fwd_rd_q;
    fwd_data_d  = fwd_data_q;
    if (wb.en && (state_q == ST_RUN)) retired_d = retired_q + 1'b1;
    if (wen) begin
      fwd_valid_d = 1'b1;
      fwd_rd_d    = wb.rd;
      fwd_data_d  = wdat;
    end

    flush_req = (state_q == ST_FLUSH);
    wb_freeze = (state_q == ST_FLUSH) || (state_q == ST_DONE);
    halt_out  = (state_q == ST_DONE);
  end

  assign wb.rf_WEN    = wen;
  assign wb.rf_wsel   = wb.rd;
  assign wb.rf_wdat   = wdat;
  assign wb.fwd_valid = fwd_valid_q;
  assign wb.fwd_rd    = fwd_rd_q;
  assign wb.fwd_data  = fwd_data_q;
  assign wb.flush_req = flush_req;
  assign wb.wb_freeze = wb_freeze;
  assign wb.halt_out  = halt_out;
  assign wb.retired   = retired_q;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the five-stage MIPS pipeline. It consumes the MEM/WB latch contents and produces the register-file write port. It keeps a one-entry bypass copy of the last committed write for the decode stage and counts retired instructions. It also sequences processor halt: on a retiring `halt` it requests a data-cache flush and raises the final halt only after the flush completes.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `en`  in  1  MEM/WB latch holds a valid instruction this cycle.
- `MemtoReg`  in  2 (`memtoreg_t`)  write-data select: 0 = ALU, 1 = LOAD, 2 = NPC, 3 = LUI.
- `RegWEN`  in  1  instruction writes a register.
- `halt`  in  1  instruction is `halt`.
- `equal`  in  1  branch compare result; ignored by this block.
- `rd`  in  5  destination register.
- `ALUOut`, `load`, `npc`, `portB`  in  32 each  write-data candidates.
- `flush_done`  in  1  data-cache flush complete.
- `rf_WEN`  out  1  register-file write enable (combinational).
- `rf_wsel`  out  5  register-file write select (combinational, equals `rd`).
- `rf_wdat`  out  32  register-file write data (combinational).
- `fwd_valid`  out  1  bypass entry is valid (registered).
- `fwd_rd`  out  5  bypass destination register (registered).
- `fwd_data`  out  32  bypass data (registered).
- `flush_req`  out  1  data-cache flush request (registered).
- `wb_freeze`  out  1  freeze the upstream pipeline (registered).
- `halt_out`  out  1  processor halted; sticky (registered).
- `retired`  out  `CNT_W`  retired-instruction count (registered).

## Operation
- FSM states: RUN (reset state), FLUSH, DONE.
- **Write-data mux:**
  - ALU selects `ALUOut`.
  - LOAD selects `load`.
  - NPC selects `npc`.
  - LUI selects `{portB[15:0],16'h0000}`.
- **Write enable:** `rf_WEN = en & RegWEN & ~halt & (rd != 0) & (state == RUN)`. A write to `rd` = 0 is suppressed.
- **Bypass entry:** on any cycle with `rf_WEN` = 1, the next edge loads `fwd_rd`/`fwd_data` with `rf_wsel`/`rf_wdat` and sets `fwd_valid`. With no write, the entry holds its value. `fwd_valid` clears only on reset.
- **Retire counter:** `retired` increments by 1 on each edge where `en` = 1 and state = RUN. The halt instruction itself counts. The counter wraps from all-ones to 0.
- **RUN:**
  - `en & halt` moves to FLUSH. No register write occurs, even if `RegWEN` = 1.
  - `flush_done` is ignored.
- **FLUSH:**
  - `flush_req` = 1 and `wb_freeze` = 1.
  - `en` is ignored: no writes, no counting.
  - Moves to DONE on the first edge that samples `flush_done` = 1.
- **DONE:**
  - `halt_out` = 1, `wb_freeze` = 1, `flush_req` = 0.
  - The block stays in DONE until `RST`. All inputs are ignored.
- Registered outputs decode from state: `flush_req` = (FLUSH), `wb_freeze` = (FLUSH|DONE), `halt_out` = (DONE).

## Timing
- **Reset:** `RST` sampled high at an edge puts every registered output at 0 after that edge: state RUN, `retired` = 0, `fwd_valid` = 0, `fwd_rd` = 0, `fwd_data` = 0, `flush_req` = 0, `wb_freeze` = 0, `halt_out` = 0. Reset overrides all other inputs in the same cycle.
- **Write latency:** `rf_*` are valid in the same cycle as the inputs; the register file captures at the next edge. The bypass entry reflects that write one cycle later.
- **Halt sequence:**
  - Halt accepted in cycle t.
  - `flush_req` and `wb_freeze` high from t+1.
  - If `flush_done` is first high in cycle t+k (k ≥ 1), `halt_out` rises at t+k+1 and `flush_req` falls at t+k+1.
  - Minimum halt latency is 2 cycles (`flush_done` already high at t+1).
- `flush_done` high in cycle t itself (still RUN) is not counted toward completion.
- Reset mid-FLUSH returns to RUN; `flush_req` drops after the reset edge.
- A write and a halt never coincide: a halt instruction never writes.

## Test plan
- Reset, then `en`=1, `RegWEN`=1, `rd`=5, `MemtoReg`=LOAD, `load`=0xDEADBEEF -> same cycle `rf_WEN`=1, `rf_wdat`=0xDEADBEEF. Next cycle `fwd_valid`=1, `fwd_rd`=5, `fwd_data`=0xDEADBEEF, `retired`=1.
- Sweep `MemtoReg` with `ALUOut`=0x11, `npc`=0x404, `portB`=0x0000ABCD -> `rf_wdat` = 0x11, 0x404, 0xABCD0000 respectively. Repeat with `rd`=0 -> `rf_WEN`=0 and the bypass entry unchanged.
- `en`=1, `halt`=1, `RegWEN`=1 at t, `flush_done` high at t+3 -> `rf_WEN`=0 at t. `flush_req`=1 for t+1..t+3. `halt_out`=1 from t+4 and stays high. `retired` is incremented once.
- During FLUSH, drive `en`=1 with writes -> no `rf_WEN`, `retired` frozen. Assert `RST` at t+2 -> all outputs 0 at t+3. A subsequent write behaves normally.
- Preload the counter to 0xFFFFFFFF (via 2^32-1 retires, or with `CNT_W`=4 and 15 retires) -> next retire gives `retired`=0.
- `flush_done` held high continuously from reset, then halt at t -> `halt_out`=1 at t+2.
